// File: rtl/burst_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_responder_if
// Description : rd_burst_* / wr_burst_* memory-burst bus between one
//               requester (master) and one responder (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface burst_mem_responder_if #(
    parameter int MEM_DATA_LEN = 64,
    parameter int ADDR_LEN     = 32
);
    logic                    rd_burst_req;
    logic                    wr_burst_req;
    logic [9:0]              rd_burst_len;
    logic [9:0]              wr_burst_len;
    logic [ADDR_LEN-1:0]     rd_burst_addr;
    logic [ADDR_LEN-1:0]     wr_burst_addr;
    logic [MEM_DATA_LEN-1:0] wr_burst_data;
    logic                    rd_burst_data_valid;
    logic [MEM_DATA_LEN-1:0] rd_burst_data;
    logic                    wr_burst_data_req;
    logic                    rd_burst_finish;
    logic                    wr_burst_finish;

    modport master (
        output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        input  rd_burst_data_valid, rd_burst_data, wr_burst_data_req,
               rd_burst_finish, wr_burst_finish
    );

    modport slave (
        input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        output rd_burst_data_valid, rd_burst_data, wr_burst_data_req,
               rd_burst_finish, wr_burst_finish
    );
endinterface
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_responder
// Description : Serves read/write bursts from one requester out of an on-chip
//               synchronous RAM, with round-robin arbitration between types.
// Revision    : 1.0  initial release
// ============================================================================
module burst_mem_responder #(
    parameter int MEM_DATA_LEN = 64,
    parameter int ADDR_LEN     = 32,
    parameter int RAM_ADDR_LEN = 10
) (
    input  wire logic             mem_clk,
    input  wire logic             rst_n,
    burst_mem_responder_if.slave  bus,
    output logic                  busy,
    output logic                  error
);
    localparam int c_ram_depth = 1 << RAM_ADDR_LEN;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_RUN  = 3'd1,
        RD_TAIL = 3'd2,
        WR_RUN  = 3'd3,
        WR_FIN  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [9:0]                r_beat;
    logic [9:0]                r_len;
    logic [RAM_ADDR_LEN-1:0]   r_addr;
    logic                      r_prio;      // 0: read wins a tie, 1: write wins
    logic                      r_error;
    logic                      r_rd_valid;
    logic [MEM_DATA_LEN-1:0]   r_rd_data;
    logic [MEM_DATA_LEN-1:0]   r_mem [0:c_ram_depth-1];

    logic                      w_grant_rd;
    logic                      w_grant_wr;
    logic                      w_acc_rd;
    logic                      w_acc_wr;
    logic                      w_last;
    logic [ADDR_LEN-1:0]       w_sel_addr;
    logic [9:0]                w_sel_len;
    logic                      w_addr_oor;
    logic [RAM_ADDR_LEN-1:0]   w_ram_idx;

    assign w_grant_rd = bus.rd_burst_req & (~bus.wr_burst_req | ~r_prio);
    assign w_grant_wr = bus.wr_burst_req & (~bus.rd_burst_req |  r_prio);
    assign w_last     = (r_beat == r_len - 10'd1);
    assign w_sel_addr = w_acc_rd ? bus.rd_burst_addr : bus.wr_burst_addr;
    assign w_sel_len  = w_acc_rd ? bus.rd_burst_len  : bus.wr_burst_len;
    assign w_ram_idx  = r_addr + RAM_ADDR_LEN'(r_beat);

    generate
        if (ADDR_LEN > RAM_ADDR_LEN) begin : g_oor
            assign w_addr_oor = |w_sel_addr[ADDR_LEN-1:RAM_ADDR_LEN];
        end else begin : g_no_oor
            assign w_addr_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_rd    = 1'b0;
        w_acc_wr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_rd) begin
                    w_acc_rd    = 1'b1;
                    w_state_nxt = (bus.rd_burst_len == 10'd0) ? RD_TAIL : RD_RUN;
                end else if (w_grant_wr) begin
                    w_acc_wr    = 1'b1;
                    w_state_nxt = (bus.wr_burst_len == 10'd0) ? WR_FIN : WR_RUN;
                end
            end
            RD_RUN:  if (w_last) w_state_nxt = RD_TAIL;
            RD_TAIL: w_state_nxt = IDLE;
            WR_RUN:  if (w_last) w_state_nxt = WR_FIN;
            WR_FIN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat     <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_prio     <= 1'b0;
            r_error    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_acc_rd || w_acc_wr) begin
                r_beat <= '0;
                r_len  <= w_sel_len;
                r_addr <= w_sel_addr[RAM_ADDR_LEN-1:0];
                r_prio <= ~r_prio;
                if (w_sel_len == 10'd0 || w_addr_oor) begin
                    r_error <= 1'b1;
                end
            end else if (r_state == RD_RUN || r_state == WR_RUN) begin
                r_beat <= r_beat + 10'd1;
            end
            // One-cycle RAM latency: the beat addressed in RD_RUN appears next cycle.
            r_rd_valid <= (r_state == RD_RUN);
            if (r_state == RD_RUN) begin
                r_rd_data <= r_mem[w_ram_idx];
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (r_state == WR_RUN) begin
            r_mem[w_ram_idx] <= bus.wr_burst_data;
        end
    end

    assign bus.rd_burst_data_valid = r_rd_valid;
    assign bus.rd_burst_data       = r_rd_data;
    assign bus.wr_burst_data_req   = (r_state == WR_RUN);
    assign bus.rd_burst_finish     = (r_state == RD_TAIL);
    assign bus.wr_burst_finish     = (r_state == WR_FIN);
    assign busy                    = (r_state != IDLE);
    assign error                   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_mem_responder
// Description : Directed self-checking bench for burst_mem_responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_burst_mem_responder;
    logic mem_clk;
    logic rst_n;
    logic busy;
    logic error;
    int   n_checks;
    int   n_errors;

    logic [63:0] wdata [0:15];
    logic [63:0] rexp  [0:15];

    burst_mem_responder_if bus ();

    burst_mem_responder dut (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .busy    (busy),
        .error   (error)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the acceptance cycle A; the task returns #1 into cycle fin+1.
    task automatic run_write(input string tag, input logic [31:0] addr, input logic [9:0] len);
        int cyc, beats, fin, first_req, busy_cnt;
        cyc = 0; beats = 0; fin = -1; first_req = -1; busy_cnt = 0;
        @(posedge mem_clk); #1;
        bus.wr_burst_req  = 1'b1;
        bus.wr_burst_addr = addr;
        bus.wr_burst_len  = len;
        while (fin < 0 && cyc < 64) begin
            if (bus.wr_burst_data_req) bus.wr_burst_data = wdata[beats % 16];
            @(negedge mem_clk);
            if (bus.wr_burst_data_req) begin
                if (first_req < 0) first_req = cyc;
                beats++;
            end
            if (busy) busy_cnt++;
            if (bus.wr_burst_finish) fin = cyc;
            @(posedge mem_clk); #1;
            cyc++;
        end
        bus.wr_burst_req = 1'b0;
        check_value({tag, " wr finish cycle"}, 64'(fin), 64'(int'(len) + 1));
        check_value({tag, " wr beats"}, 64'(beats), 64'(int'(len)));
        check_value({tag, " wr first req cycle"}, 64'(first_req), (len == 10'd0) ? 64'(-1) : 64'(1));
        check_value({tag, " wr busy cycles"}, 64'(busy_cnt), 64'(int'(len) + 1));
    endtask

    task automatic run_read(input string tag, input logic [31:0] addr, input logic [9:0] len);
        int cyc, beats, fin, first_v, last_v, busy_cnt;
        logic [63:0] got [0:15];
        cyc = 0; beats = 0; fin = -1; first_v = -1; last_v = -1; busy_cnt = 0;
        for (int i = 0; i < 16; i++) got[i] = '0;
        @(posedge mem_clk); #1;
        bus.rd_burst_req  = 1'b1;
        bus.rd_burst_addr = addr;
        bus.rd_burst_len  = len;
        while (fin < 0 && cyc < 64) begin
            @(negedge mem_clk);
            if (bus.rd_burst_data_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (beats < 16) got[beats] = bus.rd_burst_data;
                beats++;
            end
            if (busy) busy_cnt++;
            if (bus.rd_burst_finish) fin = cyc;
            @(posedge mem_clk); #1;
            cyc++;
        end
        bus.rd_burst_req = 1'b0;
        check_value({tag, " rd finish cycle"}, 64'(fin), 64'(int'(len) + 1));
        check_value({tag, " rd beats"}, 64'(beats), 64'(int'(len)));
        check_value({tag, " rd first valid"}, 64'(first_v), (len == 10'd0) ? 64'(-1) : 64'(2));
        check_value({tag, " rd last valid"}, 64'(last_v), (len == 10'd0) ? 64'(-1) : 64'(int'(len) + 1));
        check_value({tag, " rd busy cycles"}, 64'(busy_cnt), 64'(int'(len) + 1));
        for (int i = 0; i < int'(len) && i < 16; i++)
            check_value($sformatf("%s rd data[%0d]", tag, i), got[i], rexp[i]);
    endtask

    // Both requests raised together with L=2; the loser must be accepted in the
    // IDLE cycle right after the winner finishes.
    task automatic run_both(input string tag, input bit rd_first);
        int cyc, rf, wf, rv, wq, wb;
        cyc = 0; rf = -1; wf = -1; rv = -1; wq = -1; wb = 0;
        @(posedge mem_clk); #1;
        bus.rd_burst_req  = 1'b1;
        bus.rd_burst_addr = 32'h80;
        bus.rd_burst_len  = 10'd2;
        bus.wr_burst_req  = 1'b1;
        bus.wr_burst_addr = 32'h90;
        bus.wr_burst_len  = 10'd2;
        while ((rf < 0 || wf < 0) && cyc < 40) begin
            if (bus.wr_burst_data_req) bus.wr_burst_data = wdata[wb % 16];
            @(negedge mem_clk);
            if (bus.rd_burst_data_valid && rv < 0) rv = cyc;
            if (bus.wr_burst_data_req) begin
                if (wq < 0) wq = cyc;
                wb++;
            end
            if (bus.rd_burst_finish) rf = cyc;
            if (bus.wr_burst_finish) wf = cyc;
            @(posedge mem_clk); #1;
            if (rf == cyc) bus.rd_burst_req = 1'b0;
            if (wf == cyc) bus.wr_burst_req = 1'b0;
            cyc++;
        end
        bus.rd_burst_req = 1'b0;
        bus.wr_burst_req = 1'b0;
        if (rd_first) begin
            check_value({tag, " rd finish"}, 64'(rf), 64'(3));
            check_value({tag, " wr first req"}, 64'(wq), 64'(5));
            check_value({tag, " wr finish"}, 64'(wf), 64'(7));
        end else begin
            check_value({tag, " wr finish"}, 64'(wf), 64'(3));
            check_value({tag, " rd first valid"}, 64'(rv), 64'(6));
            check_value({tag, " rd finish"}, 64'(rf), 64'(7));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, " valid"},    64'(bus.rd_burst_data_valid), 64'(0));
        check_value({tag, " rd data"},  bus.rd_burst_data,            64'(0));
        check_value({tag, " data req"}, 64'(bus.wr_burst_data_req),   64'(0));
        check_value({tag, " rd fin"},   64'(bus.rd_burst_finish),     64'(0));
        check_value({tag, " wr fin"},   64'(bus.wr_burst_finish),     64'(0));
        check_value({tag, " busy"},     64'(busy),                    64'(0));
        check_value({tag, " error"},    64'(error),                   64'(0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.rd_burst_req  = 1'b0;
        bus.wr_burst_req  = 1'b0;
        bus.rd_burst_len  = '0;
        bus.wr_burst_len  = '0;
        bus.rd_burst_addr = '0;
        bus.wr_burst_addr = '0;
        bus.wr_burst_data = '0;
        for (int i = 0; i < 16; i++) begin
            wdata[i] = '0;
            rexp[i]  = '0;
        end
        repeat (3) @(posedge mem_clk);
        #1 check_all_zero("reset");
        @(negedge mem_clk);
        rst_n = 1'b1;

        // Arbitration: read wins first tie after reset; a later tie with the
        // priority bit at "write" (after a lone read) goes to the write.
        wdata[0] = 64'hA0; wdata[1] = 64'hA1;
        run_both("tie1", 1'b1);
        rexp[0] = 64'hA0;
        run_read("tie rdback", 32'h90, 10'd1);
        run_both("tie2", 1'b0);

        wdata[0] = 64'h1111_2222_3333_4444;
        run_write("single", 32'h10, 10'd1);
        rexp[0] = 64'h1111_2222_3333_4444;
        run_read("single", 32'h10, 10'd1);

        for (int i = 0; i < 8; i++) begin
            wdata[i] = 64'(i);
            rexp[i]  = 64'(i);
        end
        run_write("wrap", 32'h3FC, 10'd8);
        run_read("wrap", 32'h3FC, 10'd8);
        for (int i = 0; i < 4; i++) rexp[i] = 64'(i + 4);
        run_read("wrap low", 32'h000, 10'd4);
        @(negedge mem_clk);
        check_value("wrap error", 64'(error), 64'(0));

        wdata[0] = 64'hDEAD_BEEF_0405_0005;
        run_write("oor", 32'h0000_0405, 10'd1);
        @(negedge mem_clk);
        check_value("oor error", 64'(error), 64'(1));
        rexp[0] = 64'hDEAD_BEEF_0405_0005;
        run_read("oor rdback", 32'h005, 10'd1);

        // Reset in the middle of a long read: outputs must clear at once.
        @(posedge mem_clk); #1;
        bus.rd_burst_req  = 1'b1;
        bus.rd_burst_addr = 32'h3FC;
        bus.rd_burst_len  = 10'd16;
        repeat (4) @(posedge mem_clk);
        #2;
        check_value("midburst valid before rst", 64'(bus.rd_burst_data_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        bus.rd_burst_req = 1'b0;
        check_all_zero("midburst rst");
        repeat (2) @(posedge mem_clk);
        @(negedge mem_clk);
        rst_n = 1'b1;
        rexp[0] = 64'h1111_2222_3333_4444;
        run_read("post rst", 32'h10, 10'd1);

        run_read("zero len", 32'h20, 10'd0);
        @(negedge mem_clk);
        check_value("zero len error", 64'(error), 64'(1));
        run_read("after zero", 32'h10, 10'd1);
        @(negedge mem_clk);
        check_value("error sticky", 64'(error), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
